// File: rtl/ldtu_ham_tx_fifo_if.sv
// Handshake/bus bundle for the LiTe-DTU Hamming TX FIFO.
// LDTU_HAM_FIFO_ERR_INJ_EN adds the inject_pos upset-injection field.
interface ldtu_ham_tx_fifo_if #(
  parameter int Nbits_32  = 32,
  parameter int Nbits_ham = 38,
  parameter int ADDR_W    = 3
);
  logic                 write_en;
  logic [Nbits_32-1:0]  data_in;
  logic                 read_en;
`ifdef LDTU_HAM_FIFO_ERR_INJ_EN
  logic [5:0]           inject_pos;
`endif
  logic [Nbits_ham-1:0] data_ham_out;
  logic                 decode_signal;
  logic                 full;
  logic                 empty;
  logic [ADDR_W:0]      fill_level;
  logic [7:0]           overflow_cnt;

`ifdef LDTU_HAM_FIFO_ERR_INJ_EN
  modport master (output write_en, data_in, read_en, inject_pos,
                  input  data_ham_out, decode_signal, full, empty, fill_level, overflow_cnt);
  modport slave  (input  write_en, data_in, read_en, inject_pos,
                  output data_ham_out, decode_signal, full, empty, fill_level, overflow_cnt);
`else
  modport master (output write_en, data_in, read_en,
                  input  data_ham_out, decode_signal, full, empty, fill_level, overflow_cnt);
  modport slave  (input  write_en, data_in, read_en,
                  output data_ham_out, decode_signal, full, empty, fill_level, overflow_cnt);
`endif
endinterface

// File: rtl/ldtu_ham_tx_fifo.sv
// LiTe-DTU output FIFO write side: Hamming(38,32) encode, circular store, strobed readout.
// Define LDTU_HAM_FIFO_ERR_INJ_EN to enable single-bit upset injection on write.
module ldtu_ham_tx_fifo #(
  parameter int Nbits_32   = 32,
  parameter int Nbits_ham  = 38,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 3
) (
  input  logic             CLK_i,
  input  logic             reset_i,
  ldtu_ham_tx_fifo_if.slave bus
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(FIFO_DEPTH);

  logic [Nbits_ham-1:0] mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]      fill_q, fill_d;
  logic [7:0]           ovf_q, ovf_d;
  logic [Nbits_ham-1:0] dout_q, dout_d;
  logic                 dec_q, dec_d;
  logic                 full, empty, rd_acc, wr_acc;
  logic [Nbits_ham-1:0] cw, wr_word;
  logic [5:0]           par;

  // Position of index i is i+1; parity slots are still zero while the XORs are taken
  always_comb begin
    cw = '0;
    cw[2]     = bus.data_in[0];
    cw[6:4]   = bus.data_in[3:1];
    cw[14:8]  = bus.data_in[10:4];
    cw[30:16] = bus.data_in[25:11];
    cw[37:32] = bus.data_in[31:26];
    par = '0;
    for (int i = 0; i < Nbits_ham; i++) begin
      for (int k = 0; k < 6; k++) begin
        if ((((i + 1) >> k) & 1) == 1) par[k] = par[k] ^ cw[i];
      end
    end
    cw[0]  = par[0];
    cw[1]  = par[1];
    cw[3]  = par[2];
    cw[7]  = par[3];
    cw[15] = par[4];
    cw[31] = par[5];
  end

`ifdef LDTU_HAM_FIFO_ERR_INJ_EN
  logic [Nbits_ham-1:0] inj_mask;
  always_comb begin
    inj_mask = '0;
    if (bus.inject_pos != 6'd0 && bus.inject_pos <= 6'd38)
      inj_mask = Nbits_ham'(1) << (bus.inject_pos - 6'd1);
  end
  assign wr_word = cw ^ inj_mask;
`else
  assign wr_word = cw;
`endif

  assign full   = (fill_q == DEPTH_L);
  assign empty  = (fill_q == '0);
  assign rd_acc = bus.read_en && !empty;
  assign wr_acc = bus.write_en && (!full || rd_acc);

  always_comb begin
    wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
    fill_d   = fill_q;
    case ({wr_acc, rd_acc})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
    ovf_d = ovf_q;
    if (bus.write_en && !wr_acc && ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
    dout_d = rd_acc ? mem_q[rd_ptr_q] : dout_q;
    dec_d  = rd_acc;
  end

  always_ff @(posedge CLK_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      ovf_q    <= '0;
      dout_q   <= '0;
      dec_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      ovf_q    <= ovf_d;
      dout_q   <= dout_d;
      dec_q    <= dec_d;
    end
  end

  // Storage is deliberately not reset; stale entries are unreachable via the pointers
  always_ff @(posedge CLK_i) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_word;
  end

  assign bus.data_ham_out  = dout_q;
  assign bus.decode_signal = dec_q;
  assign bus.full          = full;
  assign bus.empty         = empty;
  assign bus.fill_level    = fill_q;
  assign bus.overflow_cnt  = ovf_q;

endmodule

// File: tb/tb_ldtu_ham_tx_fifo.sv
// Directed self-checking bench for ldtu_ham_tx_fifo (covers LDTU_HAM_FIFO_ERR_INJ_EN when defined).
module tb_ldtu_ham_tx_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ldtu_ham_tx_fifo_if bus ();
  ldtu_ham_tx_fifo dut (.CLK_i(clk), .reset_i(rst), .bus(bus));

  always #5 clk = ~clk;

  // Hand-computed codewords for single-bit/low data words
  logic [31:0] wd [8];
  logic [37:0] wc [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] syndrome(input logic [37:0] c);
    logic [5:0] s = '0;
    for (int i = 0; i < 38; i++) if (c[i]) s = s ^ 6'(i + 1);
    return s;
  endfunction

  function automatic logic [31:0] extract(input logic [37:0] c);
    return {c[37:32], c[30:16], c[14:8], c[6:4], c[2]};
  endfunction

  task automatic wr(input logic [31:0] d);
    bus.write_en = 1'b1;
    bus.data_in  = d;
    tick();
    bus.write_en = 1'b0;
  endtask

  initial begin
    wd[0] = 32'h00000001; wc[0] = 38'h0000000007;
    wd[1] = 32'h00000002; wc[1] = 38'h0000000019;
    wd[2] = 32'h00000004; wc[2] = 38'h000000002A;
    wd[3] = 32'h00000008; wc[3] = 38'h000000004B;
    wd[4] = 32'h00000010; wc[4] = 38'h0000000181;
    wd[5] = 32'h00000800; wc[5] = 38'h0000018001;
    wd[6] = 32'h04000000; wc[6] = 38'h0180000001;
    wd[7] = 32'h80000000; wc[7] = 38'h208000000A;

    bus.write_en = 1'b0;
    bus.read_en  = 1'b0;
    bus.data_in  = '0;
`ifdef LDTU_HAM_FIFO_ERR_INJ_EN
    bus.inject_pos = 6'd0;
`endif
    #12;
    check("rst_empty", 64'(bus.empty), 64'd1);
    check("rst_full", 64'(bus.full), 64'd0);
    check("rst_fill", 64'(bus.fill_level), 64'd0);
    check("rst_dout", 64'(bus.data_ham_out), 64'd0);
    check("rst_dec", 64'(bus.decode_signal), 64'd0);
    check("rst_ovf", 64'(bus.overflow_cnt), 64'd0);
    rst = 1'b0;
    tick();

    // Single word write then read
    wr(32'h00000001);
    check("w1_fill", 64'(bus.fill_level), 64'd1);
    bus.read_en = 1'b1;
    tick();
    bus.read_en = 1'b0;
    check("r1_dout", 64'(bus.data_ham_out), 64'h0000000007);
    check("r1_dec", 64'(bus.decode_signal), 64'd1);
    check("r1_empty", 64'(bus.empty), 64'd1);
    tick();
    check("r1_dec_off", 64'(bus.decode_signal), 64'd0);
    check("r1_hold", 64'(bus.data_ham_out), 64'h0000000007);

    // MSB word and decoder view of it
    wr(32'h80000000);
    bus.read_en = 1'b1;
    tick();
    bus.read_en = 1'b0;
    check("msb_dout", 64'(bus.data_ham_out), 64'h208000000A);
    check("msb_syn", 64'(syndrome(bus.data_ham_out)), 64'd0);
    check("msb_data", 64'(extract(bus.data_ham_out)), 64'h80000000);
    tick();

    // Fill to full, drop one, drain in order
    for (int i = 0; i < 8; i++) wr(wd[i]);
    check("fill8_full", 64'(bus.full), 64'd1);
    check("fill8_lvl", 64'(bus.fill_level), 64'd8);
    wr(32'hDEADBEEF);
    check("ovf1_cnt", 64'(bus.overflow_cnt), 64'd1);
    check("ovf1_lvl", 64'(bus.fill_level), 64'd8);
    bus.read_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("drain_dec", 64'(bus.decode_signal), 64'd1);
      check("drain_dout", 64'(bus.data_ham_out), 64'(wc[i]));
      check("drain_syn", 64'(syndrome(bus.data_ham_out)), 64'd0);
    end
    bus.read_en = 1'b0;
    check("drain_empty", 64'(bus.empty), 64'd1);
    tick();
    check("drain_dec_off", 64'(bus.decode_signal), 64'd0);

    // Simultaneous read+write while full
    for (int i = 0; i < 8; i++) wr(wd[i]);
    bus.write_en = 1'b1;
    bus.read_en  = 1'b1;
    bus.data_in  = 32'h00000003;
    tick();
    bus.write_en = 1'b0;
    check("fullrw_dec", 64'(bus.decode_signal), 64'd1);
    check("fullrw_dout", 64'(bus.data_ham_out), 64'h07);
    check("fullrw_lvl", 64'(bus.fill_level), 64'd8);
    check("fullrw_ovf", 64'(bus.overflow_cnt), 64'd1);
    for (int i = 1; i < 8; i++) begin
      tick();
      check("rw_drain", 64'(bus.data_ham_out), 64'(wc[i]));
    end
    tick();
    bus.read_en = 1'b0;
    check("rw_last", 64'(bus.data_ham_out), 64'h1E);
    check("rw_empty", 64'(bus.empty), 64'd1);

    // Simultaneous read+write while empty: write only
    bus.write_en = 1'b1;
    bus.read_en  = 1'b1;
    bus.data_in  = 32'h00000010;
    tick();
    bus.write_en = 1'b0;
    bus.read_en  = 1'b0;
    check("emptyrw_lvl", 64'(bus.fill_level), 64'd1);
    check("emptyrw_dec", 64'(bus.decode_signal), 64'd0);

    // Mid-stream asynchronous reset
    for (int i = 0; i < 4; i++) wr(wd[i]);
    bus.write_en = 1'b1;
    bus.read_en  = 1'b1;
    bus.data_in  = 32'h00000004;
    tick();
    bus.write_en = 1'b0;
    bus.read_en  = 1'b0;
    check("mid_lvl", 64'(bus.fill_level), 64'd5);
    check("mid_dec", 64'(bus.decode_signal), 64'd1);
    check("mid_dout", 64'(bus.data_ham_out), 64'h0181);
    #2;
    rst = 1'b1;
    #1;
    check("arst_dec", 64'(bus.decode_signal), 64'd0);
    check("arst_dout", 64'(bus.data_ham_out), 64'd0);
    check("arst_empty", 64'(bus.empty), 64'd1);
    check("arst_lvl", 64'(bus.fill_level), 64'd0);
    check("arst_ovf", 64'(bus.overflow_cnt), 64'd0);
    #1;
    rst = 1'b0;
    bus.read_en = 1'b1;
    tick();
    bus.read_en = 1'b0;
    check("post_rst_dec", 64'(bus.decode_signal), 64'd0);

    // Overflow counter saturation
    for (int i = 0; i < 8; i++) wr(wd[i]);
    bus.write_en = 1'b1;
    for (int i = 0; i < 254; i++) tick();
    check("ovf254", 64'(bus.overflow_cnt), 64'd254);
    for (int i = 0; i < 10; i++) tick();
    bus.write_en = 1'b0;
    check("ovf_sat", 64'(bus.overflow_cnt), 64'd255);
    check("ovf_lvl", 64'(bus.fill_level), 64'd8);
    bus.read_en = 1'b1;
    tick();
    bus.read_en = 1'b0;
    check("ovf_first", 64'(bus.data_ham_out), 64'(wc[0]));

`ifdef LDTU_HAM_FIFO_ERR_INJ_EN
    #2;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
    bus.inject_pos = 6'd3;
    wr(32'h00000001);
    bus.inject_pos = 6'd0;
    wr(32'h00000001);
    bus.inject_pos = 6'd39;
    wr(32'h00000001);
    bus.inject_pos = 6'd38;
    wr(32'h00000000);
    bus.inject_pos = 6'd0;
    bus.read_en = 1'b1;
    tick();
    check("inj3_dout", 64'(bus.data_ham_out), 64'h03);
    check("inj3_syn", 64'(syndrome(bus.data_ham_out)), 64'd3);
    check("inj3_data", 64'(extract(bus.data_ham_out ^ 38'h4)), 64'h1);
    tick();
    check("inj0_dout", 64'(bus.data_ham_out), 64'h07);
    tick();
    check("inj39_dout", 64'(bus.data_ham_out), 64'h07);
    tick();
    bus.read_en = 1'b0;
    check("inj38_dout", 64'(bus.data_ham_out), 64'h2000000000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ldtu_ham_tx_fifo.md
Name: ldtu_ham_tx_fifo

Overview:
- Write side of the LiTe-DTU output FIFO.
- Hamming-encodes each 32-bit data word into a 38-bit codeword and stores it in a circular buffer.
- On request, presents the oldest codeword with a one-cycle decode_signal strobe to the downstream Hamming decoder stage, which corrects single-bit upsets picked up in storage.

Parameters:
- Nbits_32, 32, data word width.
- Nbits_ham, 38, codeword width.
- FIFO_DEPTH, 8, number of stored codewords (power of two).
- ADDR_W, 3, log2(FIFO_DEPTH).

Ports:
- CLK  input  1  LiTe-DTU clock.
- reset  input  1  asynchronous, active-high reset.
- write_en  input  1  write request for data_in.
- data_in  input  32  data word to encode and store.
- read_en  input  1  read request.
- data_ham_out  output  38  codeword presented to the decoder.
- decode_signal  output  1  one-cycle strobe: data_ham_out is valid this cycle.
- full  output  1  FIFO_DEPTH words stored.
- empty  output  1  no words stored.
- fill_level  output  ADDR_W+1  current word count, 0..FIFO_DEPTH.
- overflow_cnt  output  8  saturating count of dropped writes.

Behaviour:
- Codeword index i holds Hamming position i+1.
- Parity bits sit at indices 0, 1, 3, 7, 15, 31 (p0..p5).
- Data mapping: data_in[0] → idx 2; [3:1] → idx 6:4; [10:4] → idx 14:8; [25:11] → idx 30:16; [31:26] → idx 37:32.
- pk = XOR of all data-position indices whose position (i+1) has bit k set. Result: every stored codeword has syndrome 0.
- Encoding is combinational on data_in; the encoded word is written into the memory on the accepting edge.
- Write accept = write_en && (!full || read accept in the same cycle). wr_ptr advances by 1 and wraps at FIFO_DEPTH.
- Read accept = read_en && !empty. There is no bypass: a read on an empty FIFO is ignored even if a write occurs in the same cycle.
- Read latency is 1 cycle. On the edge after a read accept, data_ham_out <= mem[rd_ptr], decode_signal = 1 for exactly that cycle, and rd_ptr advances (wraps).
- data_ham_out holds its last value while decode_signal = 0.
- fill_level: +1 on write only, -1 on read only, unchanged when both or neither occur.
- full = (fill_level == FIFO_DEPTH); empty = (fill_level == 0). Both are registered-state derived, with no same-cycle look-ahead.
- A write request with full=1 and no read accept drops the word and increments overflow_cnt. The count saturates at 255.
- Back-to-back reads return words in write order; sustained read every cycle gives decode_signal continuously high.
- Reset (asynchronous, takes effect immediately, mid-operation included):
  - wr_ptr = rd_ptr = 0, fill_level = 0, empty = 1, full = 0.
  - data_ham_out = 38'h0 (valid codeword of data 0), decode_signal = 0, overflow_cnt = 0.
  - Memory contents are not cleared; they are unreachable until rewritten.
  - Any in-flight read strobe is cancelled.

Optional Feature:
- Macro: LDTU_HAM_FIFO_ERR_INJ_EN.
- Defined:
  - Adds input inject_pos [5:0].
  - On a write accept with inject_pos in 1..38, the stored codeword has bit (inject_pos-1) inverted. This models a single-event upset for exercising the decoder.
  - inject_pos 0 or >38 leaves the word unmodified.
- Undefined: the port and logic are absent; stored words are always clean codewords.

Test Plan:
- Reset, then write data_in=32'h00000001, read next cycle → one cycle later data_ham_out=38'h0000000007, decode_signal=1 for exactly 1 cycle, empty=1.
- Write 32'h80000000 → read returns 38'h208000000A. Feeding it to the decoder gives 32'h80000000 with HammError=0.
- Write 8 distinct words → full=1, fill_level=8; 9th write → dropped, overflow_cnt=1, fill_level=8; 8 consecutive reads → all 8 words in order, decode_signal high 8 cycles, then empty=1.
- Full FIFO with write_en and read_en in the same cycle → both accepted, fill_level stays 8, overflow_cnt unchanged; empty FIFO with both asserted → write only, fill_level=1, no decode_signal.
- Assert reset mid-stream with fill_level=5 and decode_signal high → outputs immediately 0/empty=1; a following read_en produces no strobe.
- (LDTU_HAM_FIFO_ERR_INJ_EN) write 32'h00000001 with inject_pos=3 → stored/read word 38'h0000000003. The decoder reports HammError=1 and outputs 32'h00000001.
